// File: rtl/reorder_buffer_pkg.sv
// ============================================================================
// Module  : reorder_buffer_pkg
// Brief   : Shared sizing constants, opcode codes and write-back bus slicing
//           helpers for the reorder buffer and the reservation stations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package reorder_buffer_pkg;

  localparam int ROB_SIZE_LOG    = 4;
  localparam int FU_NUMBER       = 4;
  localparam int REG_INDEX_WIDTH = 5;
  localparam int VALUE_WIDTH     = 32;
  localparam int ROB_SIZE        = 1 << ROB_SIZE_LOG;

  // Function-unit opcode classes carried alongside the ROB tag at issue.
  localparam logic [3:0] OPCODE_ALU   = 4'd0;
  localparam logic [3:0] OPCODE_MUL   = 4'd1;
  localparam logic [3:0] OPCODE_LOAD  = 4'd2;
  localparam logic [3:0] OPCODE_STORE = 4'd3;
  localparam logic [3:0] OPCODE_BR    = 4'd4;

  typedef logic [ROB_SIZE_LOG-1:0] rob_pos_t;

  // Retire record as seen by the register file / store path.
  typedef struct packed {
    rob_pos_t                   position;
    logic [REG_INDEX_WIDTH-1:0] dest;
    logic [VALUE_WIDTH-1:0]     value;
    logic                       is_store;
  } rob_commit_t;

  // Target slot of FU idx on the packed write-back position bus.
  function automatic rob_pos_t wb_pos_at(
    input logic [FU_NUMBER*ROB_SIZE_LOG-1:0] bus,
    input int                                idx
  );
    return bus[idx*ROB_SIZE_LOG +: ROB_SIZE_LOG];
  endfunction

  // Result of FU idx on the packed write-back value bus.
  function automatic logic [VALUE_WIDTH-1:0] wb_value_at(
    input logic [FU_NUMBER*VALUE_WIDTH-1:0] bus,
    input int                               idx
  );
    return bus[idx*VALUE_WIDTH +: VALUE_WIDTH];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rob_wb_match.sv
// ============================================================================
// Module  : rob_wb_match
// Brief   : Searches the packed write-back bus for a given ROB tag and returns
//           the hit flag and the value of the lowest-index matching port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_wb_match
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE_LOG = reorder_buffer_pkg::ROB_SIZE_LOG,
  parameter int FU_NUMBER    = reorder_buffer_pkg::FU_NUMBER
) (
  input  logic [ROB_SIZE_LOG-1:0]           tag,
  input  logic [FU_NUMBER-1:0]              wb_valid,
  input  logic [FU_NUMBER*ROB_SIZE_LOG-1:0] wb_position,
  input  logic [FU_NUMBER*32-1:0]           wb_value,
  output logic                              hit,
  output logic [31:0]                       value
);

  // Scan from the highest port down so the lowest matching port is the last
  // one to write and therefore wins.
  always_comb begin
    hit   = 1'b0;
    value = '0;
    for (int i = FU_NUMBER - 1; i >= 0; i--) begin
      if (wb_valid[i] && (wb_position[i*ROB_SIZE_LOG +: ROB_SIZE_LOG] == tag)) begin
        hit   = 1'b1;
        value = wb_value[i*32 +: 32];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ============================================================================
// Module  : reorder_buffer
// Brief   : In-order reorder buffer: allocates slots at issue, captures
//           function-unit results, serves operand lookups with same-cycle
//           bypass and retires entries strictly in program order.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE_LOG    = reorder_buffer_pkg::ROB_SIZE_LOG,
  parameter int FU_NUMBER       = reorder_buffer_pkg::FU_NUMBER,
  parameter int REG_INDEX_WIDTH = reorder_buffer_pkg::REG_INDEX_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              alloc_valid,
  input  logic [REG_INDEX_WIDTH-1:0]        alloc_dest,
  input  logic                              alloc_is_store,
  output logic                              alloc_ready,
  output logic [ROB_SIZE_LOG-1:0]           alloc_position,
  input  logic [FU_NUMBER-1:0]              wb_valid,
  input  logic [FU_NUMBER*ROB_SIZE_LOG-1:0] wb_position,
  input  logic [FU_NUMBER*32-1:0]           wb_value,
  input  logic [ROB_SIZE_LOG-1:0]           rd_pos_j,
  input  logic [ROB_SIZE_LOG-1:0]           rd_pos_k,
  output logic                              rd_ready_j,
  output logic                              rd_ready_k,
  output logic [31:0]                       rd_value_j,
  output logic [31:0]                       rd_value_k,
  input  logic                              commit_stall,
  output logic                              commit_valid,
  output logic [ROB_SIZE_LOG-1:0]           commit_position,
  output logic [REG_INDEX_WIDTH-1:0]        commit_dest,
  output logic [31:0]                       commit_value,
  output logic                              commit_is_store,
  input  logic                              flush,
  output logic [ROB_SIZE_LOG:0]             count,
  output logic                              empty,
  output logic                              full
);

  localparam int                  C_ENTRIES = 1 << ROB_SIZE_LOG;
  localparam logic [ROB_SIZE_LOG:0] C_FULL_COUNT = (ROB_SIZE_LOG+1)'(C_ENTRIES);

  logic                       r_busy     [C_ENTRIES];
  logic                       r_ready    [C_ENTRIES];
  logic [REG_INDEX_WIDTH-1:0] r_dest     [C_ENTRIES];
  logic                       r_is_store [C_ENTRIES];
  logic [31:0]                r_value    [C_ENTRIES];

  logic [ROB_SIZE_LOG-1:0]    r_head;
  logic [ROB_SIZE_LOG-1:0]    r_tail;
  logic [ROB_SIZE_LOG:0]      r_count;

  logic                       r_commit_valid;
  logic [ROB_SIZE_LOG-1:0]    r_commit_position;
  logic [REG_INDEX_WIDTH-1:0] r_commit_dest;
  logic [31:0]                r_commit_value;
  logic                       r_commit_is_store;

  logic                       w_full;
  logic                       w_alloc_fire;
  logic                       w_commit_fire;
  logic                       w_wb_hit   [C_ENTRIES];
  logic [31:0]                w_wb_value [C_ENTRIES];
  logic                       w_hit_j;
  logic                       w_hit_k;
  logic [31:0]                w_byp_j;
  logic [31:0]                w_byp_k;

  // One matcher per entry: each slot picks its own write-back port.
  generate
    for (genvar e = 0; e < C_ENTRIES; e++) begin : g_entry_match
      rob_wb_match #(
        .ROB_SIZE_LOG (ROB_SIZE_LOG),
        .FU_NUMBER    (FU_NUMBER)
      ) u_match (
        .tag         (ROB_SIZE_LOG'(e)),
        .wb_valid    (wb_valid),
        .wb_position (wb_position),
        .wb_value    (wb_value),
        .hit         (w_wb_hit[e]),
        .value       (w_wb_value[e])
      );
    end
  endgenerate

  rob_wb_match #(
    .ROB_SIZE_LOG (ROB_SIZE_LOG),
    .FU_NUMBER    (FU_NUMBER)
  ) u_rd_match_j (
    .tag         (rd_pos_j),
    .wb_valid    (wb_valid),
    .wb_position (wb_position),
    .wb_value    (wb_value),
    .hit         (w_hit_j),
    .value       (w_byp_j)
  );

  rob_wb_match #(
    .ROB_SIZE_LOG (ROB_SIZE_LOG),
    .FU_NUMBER    (FU_NUMBER)
  ) u_rd_match_k (
    .tag         (rd_pos_k),
    .wb_valid    (wb_valid),
    .wb_position (wb_position),
    .wb_value    (wb_value),
    .hit         (w_hit_k),
    .value       (w_byp_k)
  );

  assign w_full        = (r_count == C_FULL_COUNT);
  // Allocation sees the full flag from before this edge; a commit in the
  // same cycle does not free a slot for it.
  assign w_alloc_fire  = alloc_valid && !w_full;
  assign w_commit_fire = r_busy[r_head] && r_ready[r_head] && !commit_stall;

  // Per-entry state: allocate at tail, free at head, capture first result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < C_ENTRIES; e++) begin
        r_busy[e]     <= 1'b0;
        r_ready[e]    <= 1'b0;
        r_dest[e]     <= '0;
        r_is_store[e] <= 1'b0;
        r_value[e]    <= '0;
      end
    end else if (flush) begin
      for (int e = 0; e < C_ENTRIES; e++) begin
        r_busy[e]  <= 1'b0;
        r_ready[e] <= 1'b0;
      end
    end else begin
      for (int e = 0; e < C_ENTRIES; e++) begin
        if (w_alloc_fire && (r_tail == ROB_SIZE_LOG'(e))) begin
          r_busy[e]     <= 1'b1;
          r_ready[e]    <= 1'b0;
          r_dest[e]     <= alloc_dest;
          r_is_store[e] <= alloc_is_store;
        end else if (w_commit_fire && (r_head == ROB_SIZE_LOG'(e))) begin
          r_busy[e]  <= 1'b0;
          r_ready[e] <= 1'b0;
        end else if (w_wb_hit[e] && r_busy[e] && !r_ready[e]) begin
          r_value[e] <= w_wb_value[e];
          r_ready[e] <= 1'b1;
        end
      end
    end
  end

  // Pointers, occupancy and the registered retire record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head            <= '0;
      r_tail            <= '0;
      r_count           <= '0;
      r_commit_valid    <= 1'b0;
      r_commit_position <= '0;
      r_commit_dest     <= '0;
      r_commit_value    <= '0;
      r_commit_is_store <= 1'b0;
    end else if (flush) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_commit_valid <= 1'b0;
    end else begin
      if (w_alloc_fire) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_commit_fire) begin
        r_commit_valid    <= 1'b1;
        r_commit_position <= r_head;
        r_commit_dest     <= r_dest[r_head];
        r_commit_value    <= r_value[r_head];
        r_commit_is_store <= r_is_store[r_head];
        r_head            <= r_head + 1'b1;
      end else begin
        r_commit_valid <= 1'b0;
      end
      case ({w_alloc_fire, w_commit_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Operand lookups: stored value first, else same-cycle write-back bypass.
  always_comb begin
    rd_ready_j = r_busy[rd_pos_j] && (r_ready[rd_pos_j] || w_hit_j);
    rd_ready_k = r_busy[rd_pos_k] && (r_ready[rd_pos_k] || w_hit_k);
    rd_value_j = '0;
    rd_value_k = '0;
    if (r_busy[rd_pos_j]) begin
      if (r_ready[rd_pos_j])  rd_value_j = r_value[rd_pos_j];
      else if (w_hit_j)       rd_value_j = w_byp_j;
    end
    if (r_busy[rd_pos_k]) begin
      if (r_ready[rd_pos_k])  rd_value_k = r_value[rd_pos_k];
      else if (w_hit_k)       rd_value_k = w_byp_k;
    end
  end

  assign alloc_ready     = !w_full;
  assign alloc_position  = r_tail;
  assign count           = r_count;
  assign empty           = (r_count == '0);
  assign full            = w_full;
  assign commit_valid    = r_commit_valid;
  assign commit_position = r_commit_position;
  assign commit_dest     = r_commit_dest;
  assign commit_value    = r_commit_value;
  assign commit_is_store = r_commit_is_store;

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ============================================================================
// Module  : tb_reorder_buffer
// Brief   : Self-checking bench for reorder_buffer with a retire scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid;
  logic [4:0]  alloc_dest;
  logic        alloc_is_store;
  logic        alloc_ready;
  logic [3:0]  alloc_position;
  logic [3:0]  wb_valid;
  logic [15:0] wb_position;
  logic [127:0] wb_value;
  logic [3:0]  rd_pos_j, rd_pos_k;
  logic        rd_ready_j, rd_ready_k;
  logic [31:0] rd_value_j, rd_value_k;
  logic        commit_stall;
  logic        commit_valid;
  logic [3:0]  commit_position;
  logic [4:0]  commit_dest;
  logic [31:0] commit_value;
  logic        commit_is_store;
  logic        flush;
  logic [4:0]  count;
  logic        empty, full;

  reorder_buffer u_dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_is_store(alloc_is_store),
    .alloc_ready(alloc_ready), .alloc_position(alloc_position),
    .wb_valid(wb_valid), .wb_position(wb_position), .wb_value(wb_value),
    .rd_pos_j(rd_pos_j), .rd_pos_k(rd_pos_k),
    .rd_ready_j(rd_ready_j), .rd_ready_k(rd_ready_k),
    .rd_value_j(rd_value_j), .rd_value_k(rd_value_k),
    .commit_stall(commit_stall), .commit_valid(commit_valid),
    .commit_position(commit_position), .commit_dest(commit_dest),
    .commit_value(commit_value), .commit_is_store(commit_is_store),
    .flush(flush), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int commits_seen = 0;

  typedef struct {
    logic [3:0] pos;
    logic [4:0] dest;
    logic       st;
  } exp_t;

  exp_t        sb_q[$];
  logic        m_busy  [16];
  logic        m_ready [16];
  logic [31:0] m_val   [16];
  logic [3:0]  m_tail;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    sb_q.delete();
    m_tail = '0;
    for (int i = 0; i < 16; i++) begin
      m_busy[i]  = 1'b0;
      m_ready[i] = 1'b0;
    end
  endtask

  task automatic set_wb(input int port, input logic [3:0] pos, input logic [31:0] val);
    wb_valid[port]           = 1'b1;
    wb_position[port*4 +: 4] = pos;
    wb_value[port*32 +: 32]  = val;
  endtask

  // Update the reference model with what this edge should do, then clock it.
  task automatic tick();
    exp_t e;
    logic [3:0] p;
    if (flush) begin
      model_clear();
    end else begin
      for (int i = 0; i < 4; i++) begin
        p = wb_position[i*4 +: 4];
        if (wb_valid[i] && m_busy[p] && !m_ready[p]) begin
          m_val[p]   = wb_value[i*32 +: 32];
          m_ready[p] = 1'b1;
        end
      end
      if (alloc_valid && sb_q.size() < 16) begin
        e.pos  = m_tail;
        e.dest = alloc_dest;
        e.st   = alloc_is_store;
        sb_q.push_back(e);
        m_busy[m_tail]  = 1'b1;
        m_ready[m_tail] = 1'b0;
        m_tail = m_tail + 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Retire monitor: every commit pulse must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (commit_valid === 1'b1) begin
        commits_seen++;
        if (sb_q.size() == 0) begin
          check_eq("commit_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("commit_position", commit_position, e.pos);
          check_eq("commit_dest", commit_dest, e.dest);
          check_eq("commit_is_store", commit_is_store, e.st);
          check_eq("commit_value", commit_value, m_val[e.pos]);
          m_busy[e.pos]  = 1'b0;
          m_ready[e.pos] = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; alloc_valid = 0; alloc_dest = 0; alloc_is_store = 0;
    wb_valid = 0; wb_position = 0; wb_value = 0; rd_pos_j = 0; rd_pos_k = 0;
    commit_stall = 0; flush = 0;
    for (int i = 0; i < 16; i++) m_val[i] = '0;
    model_clear();
    #12;
    check_eq("rst_alloc_ready", alloc_ready, 1);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_commit_valid", commit_valid, 0);
    reset = 1'b0;

    // In-order retire of out-of-order results.
    check_eq("t1_alloc_pos0", alloc_position, 0);
    alloc_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      alloc_dest = 5'(i);
      tick();
    end
    alloc_valid = 0;
    check_eq("t1_count3", count, 3);
    check_eq("t1_alloc_pos3", alloc_position, 3);
    set_wb(0, 4'd1, 32'h22);
    set_wb(1, 4'd0, 32'h11);
    set_wb(2, 4'd2, 32'h33);
    tick();
    wb_valid = 0;
    check_eq("t1_no_commit_yet", commit_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t1_commit_pulse", commit_valid, 1);
      check_eq("t1_count_dec", count, 5'(2 - i));
    end
    tick();
    check_eq("t1_commit_idle", commit_valid, 0);
    check_eq("t1_empty", empty, 1);
    check_eq("t1_commits_seen", commits_seen, 3);

    // Fill to capacity, overflow request, commit with alloc held.
    flush = 1; tick(); flush = 0;
    check_eq("t2_flush_pos", alloc_position, 0);
    alloc_valid = 1;
    for (int i = 0; i < 16; i++) begin
      alloc_dest = 5'(i + 8);
      alloc_is_store = i[0];
      tick();
    end
    alloc_is_store = 0;
    check_eq("t2_full", full, 1);
    check_eq("t2_alloc_ready", alloc_ready, 0);
    check_eq("t2_count16", count, 16);
    check_eq("t2_tail_wrap", alloc_position, 0);
    alloc_dest = 5'd30;
    tick();
    check_eq("t2_overflow_ignored", count, 16);
    set_wb(0, 4'd0, 32'h1234);
    tick();
    wb_valid = 0;
    check_eq("t2_ready_no_commit", commit_valid, 0);
    check_eq("t2_count_hold", count, 16);
    tick();
    check_eq("t2_commit", commit_valid, 1);
    check_eq("t2_count15", count, 15);
    check_eq("t2_alloc_ready_free", alloc_ready, 1);
    check_eq("t2_alloc_pos_wrap", alloc_position, 0);
    tick();
    check_eq("t2_refill_count", count, 16);
    check_eq("t2_refill_full", full, 1);
    check_eq("t2_refill_pos", alloc_position, 1);
    alloc_valid = 0;

    // Same-cycle bypass on the read port.
    rd_pos_j = 4'd5; rd_pos_k = 4'd6;
    set_wb(3, 4'd5, 32'hDEAD);
    #1;
    check_eq("t3_bypass_ready", rd_ready_j, 1);
    check_eq("t3_bypass_value", rd_value_j, 32'hDEAD);
    check_eq("t3_unready_k", rd_ready_k, 0);
    tick();
    wb_valid = 0;
    #1;
    check_eq("t3_stored_ready", rd_ready_j, 1);
    check_eq("t3_stored_value", rd_value_j, 32'hDEAD);

    // Port priority and write-once.
    rd_pos_k = 4'd4;
    set_wb(0, 4'd4, 32'hAAAA);
    set_wb(2, 4'd4, 32'hBBBB);
    #1;
    check_eq("t4_bypass_prio", rd_value_k, 32'hAAAA);
    tick();
    wb_valid = 0;
    #1;
    check_eq("t4_stored_prio", rd_value_k, 32'hAAAA);
    set_wb(1, 4'd4, 32'hCCCC);
    #1;
    check_eq("t4_stored_wins", rd_value_k, 32'hAAAA);
    tick();
    wb_valid = 0;
    #1;
    check_eq("t4_rewrite_ignored", rd_value_k, 32'hAAAA);

    // Non-busy lookup.
    flush = 1; tick(); flush = 0;
    set_wb(1, 4'd5, 32'h77);
    #1;
    check_eq("t4_idle_ready", rd_ready_j, 0);
    check_eq("t4_idle_value", rd_value_j, 0);
    wb_valid = 0;

    // Commit stall.
    commit_stall = 1;
    alloc_valid = 1; alloc_dest = 5'd7; alloc_is_store = 1;
    tick();
    alloc_valid = 0; alloc_is_store = 0;
    set_wb(2, 4'd0, 32'h5A5A);
    tick();
    wb_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t5_stalled", commit_valid, 0);
    end
    commit_stall = 0;
    tick();
    check_eq("t5_release", commit_valid, 1);
    tick();
    check_eq("t5_single_pulse", commit_valid, 0);

    // Flush with competing alloc / write-back / commit.
    commit_stall = 1;
    alloc_valid = 1;
    for (int i = 0; i < 5; i++) begin
      alloc_dest = 5'(10 + i);
      tick();
    end
    alloc_valid = 0;
    set_wb(0, 4'd1, 32'h100);
    tick();
    wb_valid = 0;
    check_eq("t6_count5", count, 5);
    flush = 1; alloc_valid = 1; commit_stall = 0;
    set_wb(1, 4'd2, 32'h200);
    tick();
    flush = 0; alloc_valid = 0; wb_valid = 0;
    check_eq("t6_count0", count, 0);
    check_eq("t6_empty", empty, 1);
    check_eq("t6_alloc_pos", alloc_position, 0);
    check_eq("t6_no_commit", commit_valid, 0);
    tick();
    check_eq("t6_no_commit_late", commit_valid, 0);

    // Asynchronous reset between edges.
    alloc_valid = 1; alloc_dest = 5'd9;
    tick(); tick();
    alloc_valid = 0;
    check_eq("t7_count2", count, 2);
    #1;
    reset = 1'b1;
    model_clear();
    #1;
    check_eq("t7_count", count, 0);
    check_eq("t7_empty", empty, 1);
    check_eq("t7_alloc_ready", alloc_ready, 1);
    check_eq("t7_alloc_pos", alloc_position, 0);
    check_eq("t7_commit_valid", commit_valid, 0);
    check_eq("t7_commit_dest", commit_dest, 0);
    check_eq("t7_commit_value", commit_value, 0);
    check_eq("t7_commit_store", commit_is_store, 0);
    #1;
    reset = 1'b0;

    // Back to normal operation after reset.
    alloc_valid = 1; alloc_dest = 5'd3;
    tick();
    alloc_valid = 0;
    set_wb(3, 4'd0, 32'h99);
    tick();
    wb_valid = 0;
    tick();
    check_eq("t7_post_commit", commit_valid, 1);
    tick();
    check_eq("sb_drain", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
